// File: rtl/uart_rx_bridge_if.sv
// Console receive bridge bundle: polling handshake toward the console plus the
// show-ahead FIFO read port toward the core load path.
interface uart_rx_bridge_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic          rx_en;
   logic          io_uart_in_valid;
   logic [7:0]    io_uart_in_ch;
   logic          pop;
   logic [7:0]    rd_data;
   logic          empty;
   logic          full;
   logic [CW-1:0] count;
   logic [31:0]   rx_total;

   modport master (
      input  rx_en,
      input  io_uart_in_ch,
      input  pop,
      output io_uart_in_valid,
      output rd_data,
      output empty,
      output full,
      output count,
      output rx_total
   );

   modport slave (
      output rx_en,
      output io_uart_in_ch,
      output pop,
      input  io_uart_in_valid,
      input  rd_data,
      input  empty,
      input  full,
      input  count,
      input  rx_total
   );
endinterface

// File: rtl/uart_rx_bridge.sv
// Polls the simulation console for input characters and buffers them in a show-ahead FIFO.
// Define UART_RX_BACKOFF_EN to throttle polling for BACKOFF_CYCLES after an empty (8'hFF) reply.
module uart_rx_bridge #(
   parameter int DEPTH          = 4,
   parameter int BACKOFF_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   uart_rx_bridge_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || BACKOFF_CYCLES < 1) begin : g_param_check
      $error("uart_rx_bridge: DEPTH must be a power of two >= 2 and BACKOFF_CYCLES >= 1");
   end

`ifdef UART_RX_BACKOFF_EN
   typedef enum logic [1:0] {IDLE = 2'd0, POLL = 2'd1, BACKOFF = 2'd2} state_t;
   localparam int BW = $clog2(BACKOFF_CYCLES + 1);
   logic [BW-1:0] backoff_cnt;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, POLL = 2'd1} state_t;
`endif

   state_t        state;
   state_t        next_state;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic [31:0]   total_q;
   logic          reply_empty;
   logic          push;
   logic          pop_ok;
   logic          full_q;
   logic          empty_q;

   assign reply_empty = (bus.io_uart_in_ch == 8'hFF);
   assign push        = (state == POLL) && !reply_empty;
   assign pop_ok      = bus.pop && !empty_q;
   assign full_q      = (count_q == CW'(DEPTH));
   assign empty_q     = (count_q == '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A started poll always finishes in one cycle, whatever rx_en does meanwhile.
   always_comb begin
      next_state           = state;
      bus.io_uart_in_valid = 1'b0;
      case (state)
         IDLE: begin
            if (bus.rx_en && !full_q) begin
               next_state = POLL;
            end
         end
         POLL: begin
            bus.io_uart_in_valid = 1'b1;
`ifdef UART_RX_BACKOFF_EN
            next_state = reply_empty ? BACKOFF : IDLE;
`else
            next_state = IDLE;
`endif
         end
`ifdef UART_RX_BACKOFF_EN
         BACKOFF: begin
            if (backoff_cnt == BW'(1)) begin
               next_state = IDLE;
            end
         end
`endif
         default: next_state = IDLE;
      endcase
   end

`ifdef UART_RX_BACKOFF_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         backoff_cnt <= '0;
      end else if ((state == POLL) && reply_empty) begin
         backoff_cnt <= BW'(BACKOFF_CYCLES);
      end else if (state == BACKOFF) begin
         backoff_cnt <= backoff_cnt - BW'(1);
      end
   end
`endif

   // Storage carries no reset; rd_data is masked to zero while empty instead.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= bus.io_uart_in_ch;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         total_q <= '0;
      end else begin
         if (push) begin
            wr_ptr  <= wr_ptr + AW'(1);
            total_q <= total_q + 32'd1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop_ok})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign bus.rd_data  = empty_q ? 8'h00 : mem[rd_ptr];
   assign bus.empty    = empty_q;
   assign bus.full     = full_q;
   assign bus.count    = count_q;
   assign bus.rx_total = total_q;
endmodule
